z16_dmem_responder: RTL and testbench
=====================================

// Module: z16_dmem_responder
// PURPOSE
//  Data-bus responder for the Z16 core: the memory end of the CPU load/store interface.
//  Holds a word-addressed data RAM and answers req/ack transactions after a fixed,
//  configurable number of wait states. Lets the core (or a bus bridge) be tested against
//  non-zero-latency memory. Sits between the core's load/store path and data storage.
// PARAMETERS
//  DEPTH_WORDS   256  number of 16-bit words stored; power of two, >= 2
//  WAIT_CYCLES   2    wait states inserted between request sample and ack; 0..15
// PORTS
//  i_clk     in   1   clock, rising edge
//  i_rst_n   in   1   asynchronous active-low reset
//  i_req     in   1   transaction request; held with addr/data until o_ack seen
//  i_wen     in   1   1 = write, 0 = read; qualified by i_req
//  i_addr    in   16  byte address; word index = i_addr[log2(DEPTH_WORDS):1]
//  i_wdata   in   16  write data
//  o_ack     out  1   one-cycle completion pulse
//  o_rdata   out  16  read data; valid while o_ack=1, held until next ack
//  o_busy    out  1   1 while a transaction is in progress (WAIT or RESP)
//  o_err     out  1   access error flag, valid with o_ack (only with Z16_DMEM_ERR_EN)
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): state IDLE; o_ack=0, o_busy=0, o_rdata=16'h0000, o_err=0,
//    wait counter=0. RAM contents are not reset.
//  - FSM: IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: on edge with i_req=1, latch i_wen/i_addr/i_wdata, counter<=WAIT_CYCLES,
//      go WAIT (go straight to RESP if WAIT_CYCLES==0).
//    WAIT: counter decrements each edge; when counter==1, go RESP.
//    RESP: o_ack=1 for exactly one cycle, then IDLE.
//  - Latency: request sampled at edge N -> o_ack high in the cycle after edge N+WAIT_CYCLES+1.
//  - Write commit: RAM written at the edge entering RESP. Read data is registered at that
//    same edge into o_rdata.
//  - Throughput: one transaction per WAIT_CYCLES+2 cycles. i_req is sampled only in IDLE.
//    Req/addr changes during WAIT/RESP are ignored.
//  - Initiator deasserts i_req in the ack cycle. If i_req is still 1 in the next IDLE
//    cycle, it is a new transaction.
//  - Address: i_addr[0] ignored; bits above the index are ignored (wraps modulo DEPTH_WORDS).
//  - Read of a location in the same transaction it is written: n/a (one op per transaction).
//  - Reset mid-transaction: pending op dropped, no ack, no RAM write, state IDLE.
// CONFIGURATION
//  Z16_DMEM_ERR_EN defined:
//    - Access with i_addr[0]=1 or i_addr >= 2*DEPTH_WORDS completes normally in timing,
//      with o_err=1 in the ack cycle.
//    - Write is suppressed; o_rdata=16'h0000.
//  Z16_DMEM_ERR_EN undefined: o_err tied 0; address wraps as above; no access suppressed.
// TESTING  (DEPTH_WORDS=256, WAIT_CYCLES=2 unless noted)
//  1 Write 16'h1234 @0x0010, req at edge 0 -> o_ack only in cycle after edge 3, o_busy 1
//    for cycles 1..3; then read @0x0010 -> o_rdata=16'h1234 with ack.
//  2 Wrap (ERR_EN off): write 16'hA5A5 @0x0202, read @0x0002 -> 16'hA5A5;
//    write @0x0003 aliases 0x0002.
//  3 Toggle i_addr/i_wen during WAIT -> latched values used; no extra ack;
//    o_busy=1 until ack.
//  4 Write 16'hBEEF @0x0004 (prior 16'h0001); pull i_rst_n low in WAIT -> o_ack never
//    pulses, outputs reset; read @0x0004 -> 16'h0001.
//  5 WAIT_CYCLES=0: read req at edge 0 -> ack in cycle after edge 1;
//    back-to-back reqs complete every 2 cycles.
//  6 ERR_EN: read @0x0003 -> ack with o_err=1, o_rdata=0;
//    write 16'hFFFF @0x0200 -> o_err=1, word 0 unchanged.

Source files
------------

// File: rtl/z16_dmem_responder.sv
// z16_dmem_responder: word-addressed data RAM answering req/ack transactions
// after WAIT_CYCLES wait states (IDLE -> WAIT -> RESP -> IDLE).
// Optional feature macro: Z16_DMEM_ERR_EN. When it is defined, misaligned or
// out-of-range accesses complete with o_err=1, no RAM write and zero read data.
module z16_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_wen,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic        o_ack,
    output logic [15:0] o_rdata,
    output logic        o_busy,
    output logic        o_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] WAIT_LD = CW'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            wen_q;
    logic [15:0]     addr_q;
    logic [15:0]     wdata_q;
    logic [15:0]     mem [DEPTH_WORDS];

    logic            commit_c;
    logic            op_wen_c;
    logic [15:0]     op_addr_c;
    logic [15:0]     op_wdata_c;
    logic [AW-1:0]   op_idx_c;
    logic            op_err_c;
    logic            wr_en_c;

    // Operation committed at the edge entering RESP; zero-wait requests commit from the live inputs
    always_comb begin
        commit_c   = 1'b0;
        op_wen_c   = wen_q;
        op_addr_c  = addr_q;
        op_wdata_c = wdata_q;
        case (state)
            ST_IDLE: begin
                if (i_req && (WAIT_CYCLES == 0)) begin
                    commit_c   = 1'b1;
                    op_wen_c   = i_wen;
                    op_addr_c  = i_addr;
                    op_wdata_c = i_wdata;
                end
            end
            ST_WAIT: commit_c = (cnt == CW'(1));
            default: ;
        endcase
    end

    assign op_idx_c = op_addr_c[AW:1];

`ifdef Z16_DMEM_ERR_EN
    logic err_q;

    assign op_err_c = op_addr_c[0] | ({1'b0, op_addr_c} >= 17'(2 * DEPTH_WORDS));

    // Error flag captured at commit and presented only in the ack cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
            o_err <= 1'b0;
        end else begin
            if (commit_c) begin
                err_q <= op_err_c;
            end
            o_err <= (state == ST_RESP) && err_q;
        end
    end
`else
    logic unused_addr;

    assign op_err_c    = 1'b0;
    assign o_err       = 1'b0;
    assign unused_addr = ^op_addr_c;
`endif

    assign wr_en_c = commit_c & op_wen_c & ~op_err_c;

    // Data storage; contents survive reset
    always_ff @(posedge i_clk) begin
        if (wr_en_c) begin
            mem[op_idx_c] <= op_wdata_c;
        end
    end

    // Transaction sequencer with registered ack/busy/read data
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            o_ack   <= 1'b0;
            o_busy  <= 1'b0;
            o_rdata <= 16'h0000;
        end else begin
            o_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_req) begin
                        wen_q   <= i_wen;
                        addr_q  <= i_addr;
                        wdata_q <= i_wdata;
                        o_busy  <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_RESP;
                            cnt   <= '0;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= WAIT_LD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == CW'(1)) begin
                        state <= ST_RESP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_RESP: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                    o_ack  <= 1'b1;
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase

            if (commit_c) begin
                if (op_err_c) begin
                    o_rdata <= 16'h0000;
                end else if (!op_wen_c) begin
                    o_rdata <= mem[op_idx_c];
                end
            end
        end
    end

endmodule

// File: tb/tb_z16_dmem_responder.sv
// Scoreboard bench for z16_dmem_responder: one instance with WAIT_CYCLES=2 and
// one with WAIT_CYCLES=0, exercised one at a time. Honors Z16_DMEM_ERR_EN.
module tb_z16_dmem_responder;

    localparam int unsigned DEPTH = 256;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req0, wen0, ack0, busy0, err0;
    logic [15:0] addr0, wdata0, rdata0;
    logic        req1, wen1, ack1, busy1, err1;
    logic [15:0] addr1, wdata1, rdata1;

    z16_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req0), .i_wen(wen0),
        .i_addr(addr0), .i_wdata(wdata0), .o_ack(ack0), .o_rdata(rdata0),
        .o_busy(busy0), .o_err(err0)
    );

    z16_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req1), .i_wen(wen1),
        .i_addr(addr1), .i_wdata(wdata1), .o_ack(ack1), .o_rdata(rdata1),
        .o_busy(busy1), .o_err(err1)
    );

    typedef struct {
        int unsigned sample;
        logic [15:0] rdata;
        bit          chk;
        bit          err;
    } exp_t;

    exp_t        sbq[$];
    int unsigned edge_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cur = 0;
    logic [15:0] mdl   [2][DEPTH];
    bit          known [2][DEPTH];

    always @(posedge clk) edge_cnt++;

    function automatic int unsigned wait_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic bit is_err(input logic [15:0] a);
`ifdef Z16_DMEM_ERR_EN
        return (a[0] == 1'b1) || ({1'b0, a} >= 17'(2 * DEPTH));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic cur_ack();
        return (cur == 0) ? ack0 : ack1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (edge %0d, inst %0d)", name, act, exp, edge_cnt, cur);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        if (cur == 0) begin
            req0 = r; wen0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; wen1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // Monitor: checks busy every cycle and pops one expectation per ack
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            logic        a, b, e;
            logic [15:0] rd;
            bit          eb;
            exp_t        x;
            a  = (cur == 0) ? ack0  : ack1;
            b  = (cur == 0) ? busy0 : busy1;
            e  = (cur == 0) ? err0  : err1;
            rd = (cur == 0) ? rdata0 : rdata1;
            eb = (sbq.size() > 0) && (edge_cnt >= sbq[0].sample)
                 && (edge_cnt <= sbq[0].sample + wait_of(cur));
            check("busy", 32'(b), 32'(eb));
            if (a === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_ack: got ack with no pending request (edge %0d)", edge_cnt);
                end else begin
                    x = sbq.pop_front();
                    check("ack_latency", edge_cnt, x.sample + wait_of(cur) + 1);
                    if (x.chk) check("rdata", 32'(rd), 32'(x.rdata));
                    check("err", 32'(e), 32'(x.err));
                end
            end
        end
    end

    // One transaction from the current negedge up to its ack cycle
    task automatic txn(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input bit toggle, input bit hold);
        exp_t        x;
        int unsigned idx;
        bit          er;
        bit          got;
        idx = (32'(a) >> 1) % DEPTH;
        er  = is_err(a);
        drive(1'b1, w, a, d);
        x.sample = edge_cnt + 1;
        x.err    = er;
        x.chk    = !w && (er || known[cur][idx]);
        x.rdata  = er ? 16'h0000 : mdl[cur][idx];
        sbq.push_back(x);
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (cur_ack() === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (toggle) drive(1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout: got no ack expected one within 40 cycles (addr %h)", a);
            sbq.delete();
        end else if (w && !er) begin
            mdl[cur][idx]   = d;
            known[cur][idx] = 1'b1;
        end
        if (!hold) drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack0"},   32'(ack0),   32'd0);
        check({tag, "_busy0"},  32'(busy0),  32'd0);
        check({tag, "_rdata0"}, 32'(rdata0), 32'd0);
        check({tag, "_err0"},   32'(err0),   32'd0);
        check({tag, "_ack1"},   32'(ack1),   32'd0);
        check({tag, "_busy1"},  32'(busy1),  32'd0);
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return 16'($urandom_range(0, 31));
        return 16'($urandom);
    endfunction

    initial begin
        exp_t x;
        int   gap;
        rst_n = 1'b0;
        req0 = 0; wen0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; wen1 = 0; addr1 = 0; wdata1 = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Basic write/read, W=2
        cur = 0;
        txn(1'b1, 16'h0010, 16'h1234, 1'b0, 1'b0);
        @(negedge clk);
        txn(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);

        // Aliasing of high and odd address bits
        txn(1'b1, 16'h0202, 16'hA5A5, 1'b0, 1'b0);
        txn(1'b0, 16'h0002, 16'h0000, 1'b0, 1'b1);
        txn(1'b1, 16'h0003, 16'h5A5A, 1'b0, 1'b0);
        @(negedge clk);
        txn(1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0);

        // Inputs toggled while the transaction is in flight
        txn(1'b1, 16'h0020, 16'hC0DE, 1'b1, 1'b0);
        txn(1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0);

        // Reset during WAIT drops the pending write
        txn(1'b1, 16'h0004, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 16'h0004, 16'hBEEF);
        x.sample = edge_cnt + 1;
        x.err    = 1'b0;
        x.chk    = 1'b0;
        x.rdata  = 16'h0000;
        sbq.push_back(x);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        sbq.delete();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        check("midreset_noack", 32'(ack0), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        txn(1'b0, 16'h0004, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);

        // Error-range accesses (plain wrap when the error feature is off)
        txn(1'b1, 16'h0000, 16'h1111, 1'b0, 1'b0);
        txn(1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0);
        txn(1'b1, 16'h0200, 16'hFFFF, 1'b0, 1'b0);
        txn(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);

        // Random traffic on the W=2 instance
        for (int n = 0; n < 60; n++) begin
            gap = $urandom_range(0, 2);
            txn(1'($urandom), rand_addr(), 16'($urandom), 1'($urandom), gap == 0);
            repeat (gap) @(negedge clk);
        end
        @(negedge clk);

        // Zero-wait instance: back-to-back burst, one op every two cycles
        cur = 1;
        @(negedge clk);
        txn(1'b1, 16'h0006, 16'h7777, 1'b0, 1'b1);
        txn(1'b0, 16'h0006, 16'h0000, 1'b0, 1'b1);
        for (int n = 0; n < 30; n++) begin
            txn(1'($urandom), rand_addr(), 16'($urandom), 1'b0, n != 29);
        end
        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1);
    end

endmodule
